// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: source requests, pin control and display outputs of the 7-seg arbiter
interface seg_display_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        req;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              pin_en;
    logic [1:0]        pin_sel;
    logic [2:0]        grant;
    logic [DATA_W-1:0] display_data;
    logic              display_valid;
    logic              switch_pulse;
    modport master (
        output req, data0, data1, data2, pin_en, pin_sel,
        input  grant, display_data, display_valid, switch_pulse
    );
    modport slave (
        input  req, data0, data1, data2, pin_en, pin_sel,
        output grant, display_data, display_valid, switch_pulse
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin display ownership with minimum hold, pin override and a blank gap on handover
module seg_display_arbiter #(
    parameter int                DATA_W      = 32,
    parameter int                HOLD_CYCLES = 50000000,
    parameter int                CNT_W       = 26,
    parameter logic [DATA_W-1:0] BLANK       = {DATA_W{1'b1}}
) (
    input logic                 clk,
    input logic                 rst,
    seg_display_arbiter_if.slave bus
);
    localparam logic [1:0]       IDLE     = 2'd0;
    localparam logic [1:0]       OWN      = 2'd1;
    localparam logic [1:0]       GAP      = 2'd2;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]        state, nxt, owner, nxt_owner, last_owner, rr1, rr2, rr_win;
    logic [CNT_W-1:0]  hold_cnt;
    logic [DATA_W-1:0] owner_data;
    logic              pin_active, pinned_owner, others, leave, any_sel, stay;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return v == 2'd2 ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] v);
        return 3'b001 << v;
    endfunction

    always_comb begin
        pin_active   = bus.pin_en && bus.pin_sel != 2'd3;
        pinned_owner = pin_active && bus.pin_sel == owner;
        others       = |(bus.req & ~onehot(owner));
        // a pin to someone else always evicts; otherwise a release or an expired hold under contention does
        leave        = (pin_active && !pinned_owner) ||
                       (!pinned_owner && (!bus.req[owner] || (hold_cnt == HOLD_MAX && others)));
        rr1          = inc3(last_owner);
        rr2          = inc3(rr1);
        rr_win       = bus.req[rr1] ? rr1 : bus.req[rr2] ? rr2 : last_owner;
        any_sel      = pin_active || |bus.req;
        nxt          = state == OWN ? (leave ? GAP : OWN) : (any_sel ? OWN : IDLE);
        nxt_owner    = state == OWN ? owner : pin_active ? bus.pin_sel : rr_win;
        stay         = state == OWN && nxt == OWN;
        owner_data   = owner == 2'd0 ? bus.data0 : owner == 2'd1 ? bus.data1 : bus.data2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= 2'd0;
            last_owner   <= 2'd2;
            hold_cnt     <= '0;
            bus.display_data <= BLANK;
            bus.switch_pulse <= 1'b0;
        end else begin
            state        <= nxt;
            owner        <= nxt_owner;
            if (state == OWN && nxt == GAP)
                last_owner <= owner;
            hold_cnt     <= stay ? (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + ONE) : '0;
            bus.display_data <= stay ? owner_data : BLANK;
            bus.switch_pulse <= nxt == OWN && state != OWN;
        end
    end

    assign bus.grant         = state == OWN ? onehot(owner) : 3'b000;
    assign bus.display_valid = state == OWN;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed test-plan scenarios plus random traffic against a cycle reference model
module tb_seg_display_arbiter;
    localparam int          H  = 4;
    localparam logic [31:0] BL = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_display_arbiter_if #(.DATA_W(32)) bus();
    seg_display_arbiter #(.DATA_W(32), .HOLD_CYCLES(H), .CNT_W(3), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;

    // reference: mode 0 = nobody, 1 = owned, 2 = blank gap
    int          m_mode, m_own, m_last, m_hold;
    logic [31:0] m_disp;
    logic        m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_own = 0; m_last = 2; m_hold = 0; m_disp = BL; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] d[3];
        bit pin, me, rival, quit;
        int pick;
        d[0] = bus.data0; d[1] = bus.data1; d[2] = bus.data2;
        pin = bus.pin_en && bus.pin_sel != 2'd3;
        if (m_mode == 1) begin
            me    = pin && int'(bus.pin_sel) == m_own;
            rival = 1'b0;
            for (int j = 0; j < 3; j++) if (j != m_own && bus.req[j]) rival = 1'b1;
            quit = (pin && !me) || (!me && (!bus.req[m_own] || (m_hold == H - 1 && rival)));
            m_pulse = 1'b0;
            if (quit) begin
                m_last = m_own; m_mode = 2; m_disp = BL;
            end else begin
                m_disp = d[m_own];
                if (m_hold < H - 1) m_hold++;
            end
        end else begin
            pick = -1;
            if (pin) pick = int'(bus.pin_sel);
            else for (int k = 3; k >= 1; k--) if (bus.req[(m_last + k) % 3]) pick = (m_last + k) % 3;
            m_disp = BL;
            if (pick >= 0) begin
                m_mode = 1; m_own = pick; m_hold = 0; m_pulse = 1'b1;
            end else begin
                m_mode = 0; m_pulse = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [2:0] g;
        g = m_mode == 1 ? 3'(1 << m_own) : 3'b000;
        check("grant", 32'(bus.grant), 32'(g));
        check("display_data", bus.display_data, m_disp);
        check("display_valid", 32'(bus.display_valid), 32'(m_mode == 1));
        check("switch_pulse", 32'(bus.switch_pulse), 32'(m_pulse));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_data", bus.display_data, 32'hFFFFFFFF);
        #1 rst = 1'b1;
    endtask

    logic [2:0] pat[11];

    initial begin
        bus.req = 3'b000; bus.pin_en = 1'b0; bus.pin_sel = 2'd3;
        bus.data0 = 32'hA0A0_0000; bus.data1 = 32'h0; bus.data2 = 32'hC2C2_2222;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 1'b1;

        // first grant after one cycle, data one cycle later
        bus.req = 3'b010; bus.data1 = 32'h0000_1234;
        cycle();
        check("tp1_grant", 32'(bus.grant), 32'b010);
        check("tp1_pulse", 32'(bus.switch_pulse), 32'd1);
        cycle();
        check("tp1_data", bus.display_data, 32'h0000_1234);
        check("tp1_pulse_low", 32'(bus.switch_pulse), 32'd0);
        bus.req = 3'b000;
        repeat (3) cycle();

        // alternation with hold 4 and a one-cycle gap
        pat[0] = 3'b001; pat[1] = 3'b001; pat[2] = 3'b001; pat[3] = 3'b001; pat[4]  = 3'b000;
        pat[5] = 3'b010; pat[6] = 3'b010; pat[7] = 3'b010; pat[8] = 3'b010; pat[9]  = 3'b000;
        pat[10] = 3'b001;
        bus.req = 3'b011;
        for (int i = 0; i < 11; i++) begin
            cycle();
            check("tp2_seq", 32'(bus.grant), 32'(pat[i]));
            if (i == 4) check("tp2_gap_blank", bus.display_data, BL);
        end

        // early release hands over without waiting for hold expiry
        bus.req = 3'b101;
        cycle();
        bus.req = 3'b100;
        cycle();
        check("tp3_gap", 32'(bus.grant), 32'd0);
        cycle();
        check("tp3_grant", 32'(bus.grant), 32'b100);

        // pin steals from owner 1, unpin returns to round robin
        bus.req = 3'b010;
        repeat (3) cycle();
        check("tp4_owner1", 32'(bus.grant), 32'b010);
        bus.pin_en = 1'b1; bus.pin_sel = 2'd2; bus.req = 3'b000;
        cycle();
        check("tp4_gap", 32'(bus.grant), 32'd0);
        cycle();
        check("tp4_pinned", 32'(bus.grant), 32'b100);
        bus.req = 3'b110;
        repeat (6) cycle();
        check("tp4_still_pinned", 32'(bus.grant), 32'b100);
        bus.pin_sel = 2'd3;
        repeat (2) cycle();
        check("tp4_unpinned", 32'(bus.grant), 32'b010);

        // pin and request together from idle
        bus.pin_en = 1'b0; bus.req = 3'b000;
        repeat (3) cycle();
        bus.pin_en = 1'b1; bus.pin_sel = 2'd0; bus.req = 3'b110;
        cycle();
        check("tp5_pin_wins", 32'(bus.grant), 32'b001);

        // reset mid-ownership of source 2
        bus.pin_sel = 2'd2;
        repeat (2) cycle();
        bus.pin_en = 1'b0; bus.req = 3'b100;
        cycle();
        check("tp6_owner2", 32'(bus.grant), 32'b100);
        async_reset();
        check("tp6_valid", 32'(bus.display_valid), 32'd0);
        bus.req = 3'b111;
        cycle();
        check("tp6_first", 32'(bus.grant), 32'b001);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) bus.req = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) bus.pin_en = ~bus.pin_en;
            if ($urandom_range(9) == 0) bus.pin_sel = 2'($urandom_range(3));
            if ($urandom_range(1) == 0) bus.data0 = $urandom;
            if ($urandom_range(1) == 0) bus.data1 = $urandom;
            if ($urandom_range(1) == 0) bus.data2 = $urandom;
            if ($urandom_range(199) == 0) async_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
